// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline.
// Compares D-stage operand needs (Tuse) against producer readiness (Tnew) in
// E/M, tracks the multiply/divide unit's busy window with a down-counter, and
// on a hazard freezes PC and F/D while injecting a bubble into D/E.
// The module is the only driver of F_PC_Enable.
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,   // busy cycles after a mult/multu start, must be <= 15
    parameter int DIV_CYCLES  = 10   // busy cycles after a div/divu start, must be <= 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic       D_is_md,
    input  logic [4:0] E_A3,
    input  logic [1:0] E_Tnew,
    input  logic [4:0] M_A3,
    input  logic [1:0] M_Tnew,
    input  logic       E_start,
    input  logic       E_md_div,
    output logic       F_PC_Enable,
    output logic       D_Reg_Enable,
    output logic       E_Reg_Clear,
    output logic       Busy
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    // Remaining MDU busy cycles; zero means the MDU is idle.
    logic [3:0] count;

    logic stall_rs;
    logic stall_rt;
    logic md_stall;
    logic stall;

    // MDU busy counter: a start only loads when idle, so a start issued while
    // the unit is still busy neither reloads nor restarts the window.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= 4'd0;
        end else if (E_start && (count == 4'd0)) begin
            count <= E_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Operand and MDU hazard detection. $0 is hard-wired zero and never
    // stalls; Tuse=3 (operand unused) can never be below a Tnew of at most 2.
    always_comb begin
        stall_rs = (D_rs != 5'd0) &&
                   (((E_A3 == D_rs) && (D_Tuse_rs < E_Tnew)) ||
                    ((M_A3 == D_rs) && (D_Tuse_rs < M_Tnew)));
        stall_rt = (D_rt != 5'd0) &&
                   (((E_A3 == D_rt) && (D_Tuse_rt < E_Tnew)) ||
                    ((M_A3 == D_rt) && (D_Tuse_rt < M_Tnew)));
        md_stall = D_is_md && ((count != 4'd0) || E_start);
        stall    = stall_rs | stall_rt | md_stall;
    end

    // Output drive: reset forces the pipeline to run freely with MDU idle.
    always_comb begin
        F_PC_Enable  = 1'b1;
        D_Reg_Enable = 1'b1;
        E_Reg_Clear  = 1'b0;
        Busy         = 1'b0;
        if (!Reset) begin
            F_PC_Enable  = ~stall;
            D_Reg_Enable = ~stall;
            E_Reg_Clear  = stall;
            Busy         = (count != 4'd0);
        end
    end

endmodule
